uart_rx_fifo: RTL and testbench

- Receive buffer between the uart block and the CPU memory-mapped I/O decode.
- Captures every byte the uart flags via rx_new into a circular FIFO, so bytes arriving faster than the CPU polls are not lost.
- Presents the head byte and status to the I/O decode at the existing data (0x0001) and status (0x0002) addresses.
- Runs entirely on clki. Bus strobes come from the slower cpu_clk domain and are treated as multi-cycle levels.

---
 rtl/uart_rx_fifo_pkg.sv | 13 +
 rtl/uart_rx_fifo_edge_det.sv | 26 ++
 rtl/uart_rx_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the uart receive FIFO: MMIO addresses and status bit layout.
package uart_rx_fifo_pkg;

    localparam logic [15:0] MMIO_DATA_ADDR   = 16'h0001;
    localparam logic [15:0] MMIO_STATUS_ADDR = 16'h0002;

    localparam int unsigned STATUS_W = 16;
    localparam int unsigned ST_AVAIL = 0;
    localparam int unsigned ST_TXRDY = 1;
    localparam int unsigned ST_OVF   = 3;
    localparam int unsigned ST_FULL  = 4;

endpackage

// File: rtl/uart_rx_fifo_edge_det.sv
// Registers a level and reports its rising and falling edges in the current cycle.
module uart_rx_fifo_edge_det (
    input  logic clki,
    input  logic rst_in,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);

    logic level_q;
    logic level_d;

    assign level_d = d;

    always_ff @(posedge clki or negedge rst_in) begin
        if (!rst_in) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign rise_c = d & ~level_q;
    assign fall_c = ~d & level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO between the uart and the CPU MMIO decode; pushes on rx_new rise,
// pops on the falling edge of the bus read strobe so rd_data holds for the whole CPU read.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic                clki,
    input  logic                rst_in,
    input  logic [7:0]          rx_data,
    input  logic                rx_new,
    output logic                uart_read,
    input  logic                bus_rd,
    input  logic                bus_wr,
    input  logic [15:0]         bus_wdata,
    output logic [7:0]          rd_data,
    output logic [STATUS_W-1:0] status,
    output logic [AW:0]         count
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic rx_rise_c;
    logic bus_rd_fall_c;
    logic bus_wr_fall_c;
    logic unused_rx_fall;
    logic unused_rd_rise;
    logic unused_wr_rise;
    logic [14:0] unused_wdata;

    assign unused_wdata = bus_wdata[15:1];

    uart_rx_fifo_edge_det u_rx_edge (
        .clki   (clki),
        .rst_in (rst_in),
        .d      (rx_new),
        .rise_c (rx_rise_c),
        .fall_c (unused_rx_fall)
    );

    uart_rx_fifo_edge_det u_rd_edge (
        .clki   (clki),
        .rst_in (rst_in),
        .d      (bus_rd),
        .rise_c (unused_rd_rise),
        .fall_c (bus_rd_fall_c)
    );

    uart_rx_fifo_edge_det u_wr_edge (
        .clki   (clki),
        .rst_in (rst_in),
        .d      (bus_wr),
        .rise_c (unused_wr_rise),
        .fall_c (bus_wr_fall_c)
    );

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          clr_pend_q, clr_pend_d;
    logic          uart_read_q, uart_read_d;
    logic          push_c, pop_c;

    // A pop is resolved before the push, so a full FIFO can accept a byte in the same cycle.
    always_comb begin
        pop_c       = 1'b0;
        push_c      = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        clr_pend_d  = clr_pend_q;
        uart_read_d = rx_rise_c;

        pop_c  = bus_rd_fall_c && (count_q != '0);
        push_c = rx_rise_c && ((count_q != CNT_FULL) || pop_c);

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - (AW+1)'(1);
        end

        // Clear request is sampled while the write strobe is high and acted on at its fall.
        if (bus_wr) begin
            clr_pend_d = bus_wdata[0];
        end
        if (rx_rise_c && !push_c) begin
            ovf_d = 1'b1;
        end else if (bus_wr_fall_c && clr_pend_q) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clki or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            clr_pend_q  <= 1'b0;
            uart_read_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            clr_pend_q  <= clr_pend_d;
            uart_read_q <= uart_read_d;
        end
    end

    always_ff @(posedge clki) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    always_comb begin
        status           = '0;
        status[ST_AVAIL] = (count_q != '0);
        status[ST_TXRDY] = 1'b0;
        status[ST_OVF]   = ovf_q;
        status[ST_FULL]  = (count_q == CNT_FULL);
    end

    assign rd_data   = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign count     = count_q;
    assign uart_read = uart_read_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic        clki = 1'b0;
    logic        rst_in;
    logic [7:0]  rx_data;
    logic        rx_new;
    logic        uart_read;
    logic        bus_rd;
    logic        bus_wr;
    logic [15:0] bus_wdata;
    logic [7:0]  rd_data;
    logic [15:0] status;
    logic [AW:0] count;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] model_q[$];
    logic       model_ovf = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clki      (clki),
        .rst_in    (rst_in),
        .rx_data   (rx_data),
        .rx_new    (rx_new),
        .uart_read (uart_read),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_wdata (bus_wdata),
        .rd_data   (rd_data),
        .status    (status),
        .count     (count)
    );

    always #5 clki = ~clki;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_status();
        logic full;
        logic avail;
        full  = (model_q.size() == DEPTH);
        avail = (model_q.size() != 0);
        return {11'b0, full, model_ovf, 1'b0, 1'b0, avail};
    endfunction

    function automatic logic [7:0] exp_rd();
        return (model_q.size() != 0) ? model_q[0] : 8'h00;
    endfunction

    function automatic logic [AW:0] exp_count();
        return (AW+1)'(model_q.size());
    endfunction

    task automatic tick();
        @(posedge clki);
        #1;
    endtask

    // One uart byte: rx_new rises, the ack pulse is checked, then rx_new drops.
    task automatic push_byte(input logic [7:0] b);
        rx_data = b;
        rx_new  = 1'b1;
        tick();
        vectors++;
        if (uart_read !== 1'b1) begin
            $display("FAIL uart_read_pulse: got %b expected 1", uart_read);
            miscompares++;
        end
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1'b1;
        tick();
        vectors++;
        if (uart_read !== 1'b0) begin
            $display("FAIL uart_read_width: got %b expected 0", uart_read);
            miscompares++;
        end
        rx_new = 1'b0;
        tick();
    endtask

    // One CPU read cycle: rd_data must hold during the whole high phase.
    task automatic pop_byte(input int hold);
        logic [7:0] exp;
        exp    = exp_rd();
        bus_rd = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            vectors++;
            if (rd_data !== exp) begin
                $display("FAIL rd_stable: got %h expected %h", rd_data, exp);
                miscompares++;
            end
        end
        bus_rd = 1'b0;
        tick();
        if (model_q.size() != 0) void'(model_q.pop_front());
    endtask

    task automatic write_status(input logic [15:0] w, input int hold);
        bus_wdata = w;
        bus_wr    = 1'b1;
        for (int i = 0; i < hold; i++) tick();
        vectors++;
        if (status !== exp_status()) begin
            $display("FAIL status_during_write: got %h expected %h", status, exp_status());
            miscompares++;
        end
        bus_wr = 1'b0;
        tick();
        if (w[0]) model_ovf = 1'b0;
        bus_wdata = 16'h0000;
    endtask

    // rx_new rise and bus_rd fall land on the same clock edge.
    task automatic push_pop_same_cycle(input logic [7:0] b);
        bus_rd = 1'b1;
        tick();
        tick();
        rx_data = b;
        rx_new  = 1'b1;
        bus_rd  = 1'b0;
        tick();
        vectors++;
        if (uart_read !== 1'b1) begin
            $display("FAIL simul_uart_read: got %b expected 1", uart_read);
            miscompares++;
        end
        if (model_q.size() != 0) void'(model_q.pop_front());
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1'b1;
        tick();
        rx_new = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (3) tick();
        vectors++;
        if (count !== exp_count()) begin
            $display("FAIL reset_count: got %0d expected %0d", count, exp_count()); miscompares++;
        end
        vectors++;
        if (status !== 16'h0000) begin
            $display("FAIL reset_status: got %h expected 0000", status); miscompares++;
        end
        vectors++;
        if (rd_data !== 8'h00) begin
            $display("FAIL reset_rd_data: got %h expected 00", rd_data); miscompares++;
        end
        vectors++;
        if (uart_read !== 1'b0) begin
            $display("FAIL reset_uart_read: got %b expected 0", uart_read); miscompares++;
        end
        rst_in = 1'b1;
        tick();
    endtask

    task automatic test_single();
        push_byte(8'hA5);
        vectors++;
        if (count !== exp_count() || count !== 5'd1) begin
            $display("FAIL single_count: got %0d expected 1", count); miscompares++;
        end
        vectors++;
        if (status !== exp_status()) begin
            $display("FAIL single_status: got %h expected %h", status, exp_status()); miscompares++;
        end
        vectors++;
        if (rd_data !== 8'hA5) begin
            $display("FAIL single_rd_data: got %h expected a5", rd_data); miscompares++;
        end
        pop_byte(3);
    endtask

    task automatic test_order();
        for (int i = 1; i <= 3; i++) push_byte(8'(i));
        for (int i = 0; i < 3; i++) pop_byte(10);
        vectors++;
        if (count !== exp_count()) begin
            $display("FAIL order_count: got %0d expected %0d", count, exp_count()); miscompares++;
        end
        vectors++;
        if (rd_data !== 8'h00) begin
            $display("FAIL order_empty_rd: got %h expected 00", rd_data); miscompares++;
        end
        pop_byte(2);
        vectors++;
        if (count !== exp_count() || status !== exp_status()) begin
            $display("FAIL underflow: got count %0d status %h expected %0d %h",
                     count, status, exp_count(), exp_status()); miscompares++;
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) push_byte(8'h10 + 8'(i));
        vectors++;
        if (count !== exp_count()) begin
            $display("FAIL full_count: got %0d expected %0d", count, exp_count()); miscompares++;
        end
        vectors++;
        if (status !== exp_status()) begin
            $display("FAIL full_status: got %h expected %h", status, exp_status()); miscompares++;
        end
        while (model_q.size() != 0) pop_byte(int'($urandom_range(1, 6)));
        vectors++;
        if (count !== exp_count() || status !== exp_status()) begin
            $display("FAIL drained: got count %0d status %h expected %0d %h",
                     count, status, exp_count(), exp_status()); miscompares++;
        end
    endtask

    task automatic test_ovf_clear();
        write_status(16'h0000, 8);
        vectors++;
        if (status !== exp_status()) begin
            $display("FAIL ovf_keep: got %h expected %h", status, exp_status()); miscompares++;
        end
        write_status(16'h0001, 8);
        vectors++;
        if (status !== exp_status()) begin
            $display("FAIL ovf_clear: got %h expected %h", status, exp_status()); miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        while (model_q.size() < DEPTH) push_byte(8'($urandom));
        push_pop_same_cycle(8'h5C);
        vectors++;
        if (count !== exp_count() || status !== exp_status()) begin
            $display("FAIL simul_full: got count %0d status %h expected %0d %h",
                     count, status, exp_count(), exp_status()); miscompares++;
        end
        while (model_q.size() != 0) pop_byte(2);
        push_pop_same_cycle(8'hC3);
        vectors++;
        if (count !== exp_count() || rd_data !== exp_rd()) begin
            $display("FAIL simul_empty: got count %0d rd %h expected %0d %h",
                     count, rd_data, exp_count(), exp_rd()); miscompares++;
        end
        pop_byte(2);
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 5) push_byte(8'($urandom));
            else if (op < 9) pop_byte(int'($urandom_range(1, 8)));
            else write_status(16'($urandom), int'($urandom_range(1, 5)));
            vectors++;
            if (count !== exp_count() || status !== exp_status() || rd_data !== exp_rd()) begin
                $display("FAIL random_op%0d: got count %0d status %h rd %h expected %0d %h %h",
                         n, count, status, rd_data, exp_count(), exp_status(), exp_rd());
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [7:0] b;
        push_byte(8'h77);
        b       = 8'($urandom);
        rx_data = b;
        rx_new  = 1'b1;
        tick();
        rst_in = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        #1;
        vectors++;
        if (count !== 5'd0) begin
            $display("FAIL rst_mid_count: got %0d expected 0", count); miscompares++;
        end
        tick();
        vectors++;
        if (uart_read !== 1'b0 || status !== 16'h0000) begin
            $display("FAIL rst_mid_hold: got uart_read %b status %h expected 0 0000",
                     uart_read, status); miscompares++;
        end
        rst_in = 1'b1;
        tick();
        vectors++;
        if (uart_read !== 1'b1) begin
            $display("FAIL rst_release_ack: got %b expected 1", uart_read); miscompares++;
        end
        model_q.push_back(b);
        tick();
        rx_new = 1'b0;
        tick();
        vectors++;
        if (count !== exp_count() || rd_data !== b) begin
            $display("FAIL rst_release_push: got count %0d rd %h expected 1 %h",
                     count, rd_data, b); miscompares++;
        end
    endtask

    initial begin
        rst_in    = 1'b0;
        rx_data   = 8'h00;
        rx_new    = 1'b0;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_wdata = 16'h0000;
        test_reset();
        test_single();
        test_order();
        test_overflow();
        test_ovf_clear();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
